// File: rtl/mc_sim_harness.sv
// Run controller for the multi-cycle CPU:
// program load, reset hold, bounded run, then a register dump stream.
module mc_sim_harness #(
  parameter int DW         = 32,
  parameter int AW         = 8,
  parameter int DEPTH      = 256,
  parameter int RST_HOLD   = 2,
  parameter int RUN_CYCLES = 10,
  parameter int REG_CNT    = 32,
  parameter int RSEL_W     = 5
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              halt_req,
  input  logic              ld_valid,
  input  logic [DW-1:0]     ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  output logic              cpu_rstn,
  output logic              cpu_ce,
  output logic [RSEL_W-1:0] reg_sel,
  input  logic [DW-1:0]     reg_data,
  output logic              dump_valid,
  output logic [RSEL_W-1:0] dump_idx,
  output logic [DW-1:0]     dump_data,
  input  logic              dump_ready,
  output logic              busy,
  output logic              done,
  output logic              err_ovf
);

  localparam int HOLD = (RST_HOLD < 1) ? 1 : RST_HOLD;
  localparam logic [AW-1:0]     LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [RSEL_W-1:0] LAST_IDX  = RSEL_W'(REG_CNT - 1);
  localparam logic [31:0]       HOLD_LAST = 32'(HOLD - 1);
  localparam logic [31:0]       RUN_LAST  = 32'(RUN_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, RSTW, RUN, DSEL, DOUT, DONE
  } state_t;

  state_t            state, nxt;
  logic [AW-1:0]     wcnt;
  logic [31:0]       hcnt;
  logic [31:0]       rcnt;
  logic [RSEL_W-1:0] idx;
  logic              acc;
  logic              go;
  logic              run_end;

  assign acc     = ld_valid && (state == LOAD);
  assign go      = start && ((state == IDLE) || (state == DONE));
  assign run_end = (RUN_CYCLES != 0) && (rcnt == RUN_LAST);
  assign reg_sel = idx;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= nxt;
  end

  // Next-state and per-state control outputs
  always_comb begin
    nxt        = state;
    ld_ready   = 1'b0;
    cpu_rstn   = 1'b0;
    cpu_ce     = 1'b0;
    dump_valid = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) nxt = LOAD;
      end
      LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid && (ld_last || wcnt == LAST_ADDR))
          nxt = RSTW;
      end
      RSTW: begin
        if (hcnt == HOLD_LAST) nxt = RUN;
      end
      RUN: begin
        cpu_rstn = 1'b1;
        cpu_ce   = 1'b1;
        if (halt_req || run_end) nxt = DSEL;
      end
      DSEL: begin
        cpu_rstn = 1'b1;
        nxt      = DOUT;
      end
      DOUT: begin
        cpu_rstn   = 1'b1;
        dump_valid = 1'b1;
        if (dump_ready)
          nxt = (idx == LAST_IDX) ? DONE : DSEL;
      end
      DONE: begin
        cpu_rstn = 1'b1;
        busy     = 1'b0;
        done     = 1'b1;
        if (start) nxt = LOAD;
      end
      default: nxt = IDLE;
    endcase
  end

  // Load write pipeline, hold/run/dump counters, sticky overflow
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wcnt      <= '0;
      hcnt      <= '0;
      rcnt      <= '0;
      idx       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      dump_idx  <= '0;
      dump_data <= '0;
      err_ovf   <= 1'b0;
    end else begin
      mem_we <= acc;
      if (acc) begin
        mem_addr  <= wcnt;
        mem_wdata <= ld_data;
        wcnt      <= wcnt + AW'(1);
      end
      if (go) begin
        wcnt    <= '0;
        err_ovf <= 1'b0;
      end else if (acc && !ld_last && wcnt == LAST_ADDR) begin
        err_ovf <= 1'b1;
      end
      hcnt <= (state == RSTW) ? hcnt + 32'd1 : 32'd0;
      rcnt <= (state == RUN) ? rcnt + 32'd1 : 32'd0;
      if (state == RUN)
        idx <= '0;
      else if (state == DOUT && dump_ready && idx != LAST_IDX)
        idx <= idx + RSEL_W'(1);
      if (state == DSEL) begin
        dump_data <= reg_data;
        dump_idx  <= idx;
      end
    end
  end

endmodule

// File: tb/tb_mc_sim_harness.sv
// Bench for mc_sim_harness: budgeted run on one instance,
// halt-only run on a second instance with RUN_CYCLES=0.
module tb_mc_sim_harness;

  localparam int DW   = 32;
  localparam int AW   = 8;
  localparam int RS   = 5;
  localparam int NREG = 32;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0, halt_req = 1'b0;
  logic          ld_valid = 1'b0, ld_last = 1'b0;
  logic          dump_ready = 1'b0;
  logic [DW-1:0] ld_data = '0;
  logic [DW-1:0] reg_data;
  logic          ld_ready, mem_we, cpu_rstn, cpu_ce;
  logic          dump_valid, busy, done, err_ovf;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, dump_data;
  logic [RS-1:0] reg_sel, dump_idx;

  logic          b_start = 1'b0, b_halt = 1'b0;
  logic          b_ld_valid = 1'b0, b_ld_last = 1'b0;
  logic          b_dump_ready = 1'b0;
  logic [DW-1:0] b_ld_data = 32'h20080005;
  logic [DW-1:0] b_reg_data;
  logic          b_ld_ready, b_mem_we, b_cpu_rstn, b_cpu_ce;
  logic          b_dump_valid, b_busy, b_done, b_err_ovf;
  logic [AW-1:0] b_mem_addr;
  logic [DW-1:0] b_mem_wdata, b_dump_data;
  logic [RS-1:0] b_reg_sel, b_dump_idx;

  int passed = 0;
  int total  = 0;

  logic [DW-1:0] ccnt, b_ccnt;
  logic [AW+DW-1:0] exp_wr[$];
  logic [RS+DW-1:0] exp_dump[$];
  logic [DW-1:0] words [6] = '{32'h20080005, 32'h20090003,
                               32'h01095020, 32'hAC0A0000,
                               32'h11111111, 32'h22222222};

  int acc_n, wr_n, ce_n, beats, last_wr_t, rise_t, stall_n;

  function automatic logic [DW-1:0] reg_val(int i, logic [DW-1:0] cnt);
    case (i)
      0:       return '0;
      8:       return 32'd5;
      9:       return 32'd3;
      10:      return 32'd8;
      31:      return cnt;
      default: return 32'hC0DE0000 | DW'(i);
    endcase
  endfunction

  // CPU stand-ins: r31 counts enabled cycles, cleared in reset
  always @(posedge clk) begin
    if (!cpu_rstn) ccnt <= '0;
    else if (cpu_ce) ccnt <= ccnt + 32'd1;
  end
  always @(posedge clk) begin
    if (!b_cpu_rstn) b_ccnt <= '0;
    else if (b_cpu_ce) b_ccnt <= b_ccnt + 32'd1;
  end

  assign reg_data   = reg_val(int'(reg_sel), ccnt);
  assign b_reg_data = reg_val(int'(b_reg_sel), b_ccnt);

  wire [89:0] outs_a = {ld_ready, mem_we, mem_addr, mem_wdata,
                        cpu_rstn, cpu_ce, reg_sel, dump_valid,
                        dump_idx, dump_data, busy, done, err_ovf};
  wire [89:0] outs_b = {b_ld_ready, b_mem_we, b_mem_addr, b_mem_wdata,
                        b_cpu_rstn, b_cpu_ce, b_reg_sel, b_dump_valid,
                        b_dump_idx, b_dump_data, b_busy, b_done,
                        b_err_ovf};

  mc_sim_harness #(.DEPTH(4), .RUN_CYCLES(10)) u_dut (
    .clk(clk), .rstn(rstn), .start(start), .halt_req(halt_req),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_rstn(cpu_rstn), .cpu_ce(cpu_ce),
    .reg_sel(reg_sel), .reg_data(reg_data), .dump_valid(dump_valid),
    .dump_idx(dump_idx), .dump_data(dump_data),
    .dump_ready(dump_ready), .busy(busy), .done(done),
    .err_ovf(err_ovf)
  );

  mc_sim_harness #(.DEPTH(4), .RUN_CYCLES(0)) u_dut0 (
    .clk(clk), .rstn(rstn), .start(b_start), .halt_req(b_halt),
    .ld_valid(b_ld_valid), .ld_data(b_ld_data), .ld_last(b_ld_last),
    .ld_ready(b_ld_ready), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .cpu_rstn(b_cpu_rstn), .cpu_ce(b_cpu_ce),
    .reg_sel(b_reg_sel), .reg_data(b_reg_data),
    .dump_valid(b_dump_valid), .dump_idx(b_dump_idx),
    .dump_data(b_dump_data), .dump_ready(b_dump_ready),
    .busy(b_busy), .done(b_done), .err_ovf(b_err_ovf)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (outs_a !== '0) $display("FAIL reset_a outs got %h want 0", outs_a);
    else passed++;
    total++;
    if (outs_b !== '0) $display("FAIL reset_b outs got %h want 0", outs_b);
    else passed++;
    @(posedge clk);
    #1 rstn = 1'b1;
    cyc();
    total++;
    if ({busy, done, cpu_rstn} !== 3'b000)
      $display("FAIL idle_after_reset got %b want 000",
               {busy, done, cpu_rstn});
    else passed++;
  endtask

  // One full session on instance A with scoreboarded writes and dumps
  task automatic session(input int nw, input bit use_last, input bit slow);
    int i;
    int t;
    bit held;
    logic [RS-1:0]    h_idx;
    logic [DW-1:0]    h_data;
    logic [AW+DW-1:0] w;
    logic [RS+DW-1:0] d;
    i = 0;
    held = 1'b0;
    h_idx = '0;
    h_data = '0;
    exp_wr.delete();
    exp_dump.delete();
    for (int k = 0; k < NREG; k++)
      exp_dump.push_back({RS'(k), reg_val(k, 32'd10)});
    acc_n = 0; wr_n = 0; ce_n = 0; beats = 0;
    last_wr_t = -1; rise_t = -1; stall_n = 0;
    dump_ready = !slow;
    start = 1'b1;
    cyc();
    start = 1'b0;
    ld_valid = 1'b1;
    ld_data  = words[0];
    ld_last  = use_last && nw == 1;
    for (t = 0; t < 2000 && !done; t++) begin
      @(negedge clk);
      if (mem_we) begin
        wr_n++;
        last_wr_t = t;
        total++;
        if (exp_wr.size() == 0)
          $display("FAIL wr_extra got addr %0d want none", mem_addr);
        else begin
          w = exp_wr.pop_front();
          if ({mem_addr, mem_wdata} !== w)
            $display("FAIL wr got %h_%h want %h_%h", mem_addr,
                     mem_wdata, w[AW+DW-1:DW], w[DW-1:0]);
          else passed++;
        end
      end
      if (cpu_rstn && rise_t < 0) rise_t = t;
      if (cpu_ce) ce_n++;
      if (dump_valid) begin
        if (held) begin
          total++;
          if ({dump_idx, dump_data} !== {h_idx, h_data})
            $display("FAIL stall_hold got %0d/%h want %0d/%h",
                     dump_idx, dump_data, h_idx, h_data);
          else passed++;
        end
        if (dump_ready) begin
          beats++;
          held = 1'b0;
          total++;
          if (exp_dump.size() == 0)
            $display("FAIL dump_extra got idx %0d want none", dump_idx);
          else begin
            d = exp_dump.pop_front();
            if ({dump_idx, dump_data} !== d)
              $display("FAIL dump got %0d/%h want %0d/%h", dump_idx,
                       dump_data, d[RS+DW-1:DW], d[DW-1:0]);
            else passed++;
          end
        end else begin
          held = 1'b1;
          h_idx = dump_idx;
          h_data = dump_data;
          stall_n++;
        end
      end else held = 1'b0;
      if (ld_valid && ld_ready) begin
        exp_wr.push_back({AW'(acc_n), ld_data});
        acc_n++;
        i++;
      end
      @(posedge clk);
      #1;
      ld_valid   = i < nw;
      ld_data    = words[(i < nw) ? i : 0];
      ld_last    = use_last && i == nw - 1;
      dump_ready = slow ? (t % 3 == 2) : 1'b1;
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    total++;
    if (!done) $display("FAIL session_timeout got done=%b want 1", done);
    else passed++;
    total++;
    if (exp_wr.size() != 0 || exp_dump.size() != 0)
      $display("FAIL leftovers got wr=%0d dump=%0d want 0/0",
               exp_wr.size(), exp_dump.size());
    else passed++;
  endtask

  task automatic test_load_run();
    session(4, 1'b1, 1'b0);
    total++;
    if (acc_n != 4 || wr_n != 4)
      $display("FAIL load_count got acc=%0d wr=%0d want 4/4", acc_n, wr_n);
    else passed++;
    total++;
    if (rise_t - last_wr_t != 2)
      $display("FAIL rst_hold got %0d want 2", rise_t - last_wr_t);
    else passed++;
    total++;
    if (ce_n != 10) $display("FAIL run_budget got %0d want 10", ce_n);
    else passed++;
    total++;
    if (err_ovf !== 1'b0 || beats != 32)
      $display("FAIL load_end got ovf=%b beats=%0d want 0/32",
               err_ovf, beats);
    else passed++;
  endtask

  task automatic test_dump_stall();
    session(4, 1'b1, 1'b1);
    total++;
    if (stall_n == 0 || beats != 32)
      $display("FAIL dump_stall got stalls=%0d beats=%0d want >0/32",
               stall_n, beats);
    else passed++;
    total++;
    if (ce_n != 10) $display("FAIL stall_budget got %0d want 10", ce_n);
    else passed++;
  endtask

  task automatic test_overflow();
    session(6, 1'b0, 1'b0);
    total++;
    if (acc_n != 4 || wr_n != 4)
      $display("FAIL ovf_count got acc=%0d wr=%0d want 4/4", acc_n, wr_n);
    else passed++;
    total++;
    if (err_ovf !== 1'b1 || done !== 1'b1)
      $display("FAIL ovf_flag got ovf=%b done=%b want 1/1", err_ovf, done);
    else passed++;
  endtask

  task automatic test_halt();
    int t;
    int ce;
    int last_ce_t;
    int first_dv_t;
    int bb;
    logic [RS+DW-1:0] exp_b[$];
    logic [RS+DW-1:0] d;
    ce = 0; last_ce_t = -1; first_dv_t = -1; bb = 0;
    for (int k = 0; k < NREG; k++)
      exp_b.push_back({RS'(k), reg_val(k, 32'd37)});
    b_dump_ready = 1'b1;
    b_start = 1'b1;
    cyc();
    b_start = 1'b0;
    b_ld_valid = 1'b1;
    b_ld_last  = 1'b1;
    cyc();
    b_ld_valid = 1'b0;
    b_ld_last  = 1'b0;
    for (t = 0; t < 300 && !b_done; t++) begin
      if (b_cpu_ce) begin
        ce++;
        last_ce_t = t;
      end
      b_halt = b_cpu_ce && ce == 37;
      @(negedge clk);
      if (b_dump_valid) begin
        if (first_dv_t < 0) first_dv_t = t;
        bb++;
        total++;
        if (exp_b.size() == 0)
          $display("FAIL halt_dump_extra got idx %0d want none", b_dump_idx);
        else begin
          d = exp_b.pop_front();
          if ({b_dump_idx, b_dump_data} !== d)
            $display("FAIL halt_dump got %0d/%h want %0d/%h", b_dump_idx,
                     b_dump_data, d[RS+DW-1:DW], d[DW-1:0]);
          else passed++;
        end
      end
      @(posedge clk);
      #1;
    end
    b_halt = 1'b0;
    total++;
    if (ce != 37) $display("FAIL halt_ce got %0d want 37", ce);
    else passed++;
    total++;
    if (first_dv_t - last_ce_t != 2)
      $display("FAIL halt_to_dump got %0d want 2", first_dv_t - last_ce_t);
    else passed++;
    total++;
    if (b_done !== 1'b1 || bb != 32)
      $display("FAIL halt_end got done=%b beats=%0d want 1/32", b_done, bb);
    else passed++;
  endtask

  task automatic test_midrun_reset();
    int t;
    start = 1'b1;
    cyc();
    start = 1'b0;
    ld_valid = 1'b1;
    ld_data  = words[2];
    ld_last  = 1'b1;
    cyc();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    total++;
    if (err_ovf !== 1'b0)
      $display("FAIL ovf_clear got %b want 0", err_ovf);
    else passed++;
    for (t = 0; t < 20 && !cpu_ce; t++) cyc();
    repeat (3) cyc();
    total++;
    if (cpu_ce !== 1'b1) $display("FAIL midrun_in_run got %b want 1", cpu_ce);
    else passed++;
    rstn = 1'b0;
    #1;
    total++;
    if (outs_a !== '0) $display("FAIL midrun_reset got %h want 0", outs_a);
    else passed++;
    cyc();
    rstn = 1'b1;
    cyc();
    total++;
    if ({busy, done} !== 2'b00)
      $display("FAIL midrun_idle got %b want 00", {busy, done});
    else passed++;
    session(4, 1'b1, 1'b0);
    total++;
    if (wr_n != 4 || ce_n != 10 || beats != 32)
      $display("FAIL resume got wr=%0d ce=%0d beats=%0d want 4/10/32",
               wr_n, ce_n, beats);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_load_run();
    test_dump_stall();
    test_overflow();
    test_halt();
    test_midrun_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mc_sim_harness.md
Name: mc_sim_harness

Overview:
- Synthesizable, parametrised run controller for the multi-cycle CPU; replaces the fixed load/reset/wait/reg-probe testbench sequence.
- Streams a program image into memory through a write port, holds the CPU in reset for a programmable time, then runs it for a cycle budget or until halted.
- Freezes the CPU afterwards and dumps REG_CNT registers through the reg_sel/reg_data probe onto a valid/ready stream.
- Usable both on FPGA and in simulation.

Parameters:
- DW, 32, data width of load words, memory and register probe.
- AW, 8, memory word-address width.
- DEPTH, 256, maximum words loadable (≤ 2^AW).
- RST_HOLD, 2, cycles cpu_rstn held low after load (minimum 1; 0 treated as 1).
- RUN_CYCLES, 10, CPU run budget in clk cycles; 0 = unlimited, exit on halt_req only.
- REG_CNT, 32, registers dumped, indices 0..REG_CNT-1.
- RSEL_W, 5, width of reg_sel / dump_idx.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a session from IDLE or DONE.
- halt_req  in  1  early-stop request from CPU or bench.
- ld_valid  in  1  load word valid.
- ld_data  in  DW  load word.
- ld_last  in  1  marks the final load word.
- ld_ready  out  1  harness accepts load word.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory word address.
- mem_wdata  out  DW  memory write data.
- cpu_rstn  out  1  CPU reset, active-low.
- cpu_ce  out  1  CPU clock enable.
- reg_sel  out  RSEL_W  register probe select.
- reg_data  in  DW  register probe data (combinational from CPU).
- dump_valid  out  1  dump word valid.
- dump_idx  out  RSEL_W  index of dumped register.
- dump_data  out  DW  dumped register value.
- dump_ready  in  1  dump consumer ready.
- busy  out  1  high in LOAD through DUMP.
- done  out  1  high in DONE.
- err_ovf  out  1  sticky; load exceeded DEPTH.

Behaviour:
- Reset (rstn low, async, any state):
  - FSM goes to IDLE; all counters cleared.
  - Every output goes to 0, including cpu_rstn (CPU held in reset).
- FSM states: IDLE, LOAD, RSTW, RUN, DSEL, DOUT, DONE. start is ignored outside IDLE/DONE.
- IDLE:
  - cpu_rstn=0, cpu_ce=0, ld_ready=0.
  - start -> LOAD; clears the word counter, done and err_ovf.
- LOAD:
  - ld_ready=1.
  - Accept on ld_valid&ld_ready. In the next cycle: mem_we=1, mem_addr=counter, mem_wdata=accepted word. Counter then increments.
  - mem_we is 0 in every cycle without a preceding accept.
  - Accept with ld_last=1 -> RSTW.
  - Accept at counter==DEPTH-1 with ld_last=0 -> RSTW and set err_ovf; remaining words are not accepted (ld_ready=0 from the next cycle).
  - ld_ready drops in the cycle after the final accept.
- RSTW:
  - cpu_rstn=0 for exactly max(RST_HOLD,1) cycles (the final LOAD write completes in the first of them), then RUN.
- RUN:
  - cpu_rstn=1, cpu_ce=1; cycle counter starts at 0.
  - Exit to DSEL when halt_req=1, or when RUN_CYCLES≠0 and the counter reaches RUN_CYCLES-1. cpu_ce is then high for exactly RUN_CYCLES cycles.
  - If halt_req coincides with budget expiry, a single exit occurs; behaviour is identical.
- DSEL:
  - cpu_ce=0, cpu_rstn=1 (CPU state frozen, not reset).
  - reg_sel=idx; the next edge captures reg_data into dump_data, sets dump_idx=idx, goes to DOUT.
- DOUT:
  - dump_valid=1. dump_data/dump_idx are stable while dump_ready=0.
  - Handshake with idx<REG_CNT-1 -> idx+1, DSEL (dump_valid low one cycle).
  - Handshake with idx==REG_CNT-1 -> DONE.
- DONE:
  - done=1, cpu_ce=0, cpu_rstn=1; err_ovf holds.
  - start -> LOAD, which re-asserts CPU reset in RSTW.
- Widths:
  - Address counter is AW bits and never wraps: the DEPTH limit triggers first.
  - Run counter is 32 bits unsigned.
  - idx counter is RSEL_W bits.

Test Plan:
- Load 4 words 0x20080005,0x20090003,0x01095020,0xAC0A0000 (last on 4th), RUN_CYCLES=10 -> mem_we at addr 0..3 with exact data, cpu_rstn low exactly 2 cycles after the last write cycle, cpu_ce high exactly 10 cycles, err_ovf=0.
- Dump after run with CPU regs r8=5,r9=3,r10=8, dump_ready stuck at 1 -> 32 dump beats, idx 0..31, dump_data correct, done=1 after idx 31.
- dump_ready toggled 1-of-3 cycles -> dump_data/dump_idx stable while stalled, no beat lost or duplicated.
- DEPTH=4, stream 6 words without ld_last -> only addr 0..3 written, ld_ready low afterwards, err_ovf=1, session continues to DONE.
- RUN_CYCLES=0, halt_req pulsed at run cycle 37 -> cpu_ce high exactly 37 cycles, then dump starts.
- rstn low mid-RUN, then start re-issued -> all outputs 0 immediately (cpu_rstn=0), state IDLE, new session runs cleanly from addr 0.
